// File: rtl/general_timer_pkg.sv
// Shared types and status-bit layout for the multi-channel timer.
// No logic; constants and a helper only.
// Not applicable.
package general_timer_pkg;

  typedef enum logic {
    CH_MODE_COMPARE = 1'b0,
    CH_MODE_CAPTURE = 1'b1
  } ch_mode_e;

  // Bit 0 of the status/irq vectors is the counter overflow flag.
  localparam int STAT_OVF = 0;

  // Channel i owns status/irq bit i+1.
  function automatic int stat_ch(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/general_timer_channel.sv
// One capture/compare channel: PWM compare register or synchronised input capture.
// PWM updates on the same edge as the counter; capture lands two edges after first sample.
// No backpressure; event_o is a single-cycle combinational strobe for the status logic.
module general_timer_channel
  import general_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] cmp_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] count_nxt_i,
  input  logic             adv_i,
  input  logic             capture_i,
  output logic             pwm_o,
  output logic [CNT_W-1:0] cap_val_o,
  output logic             event_o
);

  ch_mode_e         mode;
  logic             mode_q, mode_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             rise;
  logic             match;

  // Next-state for compare output, synchroniser chain and capture register.
  // History keeps following the synchroniser in both modes and the first cycle
  // after a mode switch is masked, so a level already high is never seen as an edge.
  always_comb begin
    mode    = ch_mode_e'(mode_i);
    mode_d  = mode_i;
    sync1_d = capture_i;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise    = (mode == CH_MODE_CAPTURE) && (mode_q == mode_i) && sync2_q && !hist_q;
    match   = (mode == CH_MODE_COMPARE) && adv_i && (count_nxt_i == cmp_i);
    pwm_d   = (mode == CH_MODE_COMPARE) && (count_nxt_i < cmp_i);
    cap_d   = rise ? count_i : cap_q;
    event_o = match || rise;
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      pwm_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pwm_q   <= pwm_d;
      cap_q   <= cap_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign cap_val_o = cap_q;

endmodule

// File: rtl/general_timer_mc.sv
// Multi-channel timer: shared prescaler/up-counter, NCH capture/compare channels, sticky status and irq.
// Counter, PWM and trigger are registered (1 edge); irq is combinational from registered status.
// No backpressure; status flags stay set until cleared by irq_clr_i, a same-cycle set wins.
module general_timer_mc
  import general_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               sw_clr_i,
  input  logic [PSC_W-1:0]   prescale_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [NCH-1:0]     ch_mode_i,
  input  logic [NCH*CNT_W-1:0] cmp_i,
  input  logic [NCH-1:0]     capture_i,
  input  logic [NCH:0]       irq_en_i,
  input  logic [NCH:0]       irq_clr_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [NCH*CNT_W-1:0] cap_val_o,
  output logic [NCH-1:0]     pwm_o,
  output logic               trigger_o,
  output logic [NCH:0]       status_o,
  output logic               irq
);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             trigger_q, trigger_d;
  logic [NCH:0]     status_q, status_d;
  logic [NCH:0]     status_set;
  logic [NCH-1:0]   ch_evt;
  logic             tick;
  logic             adv;
  logic             wrap;

  // Prescaler and counter next-state; a software clear overrides a tick and never wraps.
  always_comb begin
    tick    = en_i && (psc_q == prescale_i);
    adv     = tick && !sw_clr_i;
    wrap    = adv && (count_q == period_i);
    psc_d   = psc_q;
    count_d = count_q;
    if (sw_clr_i) begin
      psc_d   = '0;
      count_d = '0;
    end else if (tick) begin
      psc_d   = '0;
      count_d = (count_q == period_i) ? '0 : count_q + 1'b1;
    end else if (en_i) begin
      psc_d = psc_q + 1'b1;
    end
    trigger_d = wrap;
  end

  // Sticky status: events OR in after the write-1-to-clear so a simultaneous set wins.
  always_comb begin
    status_set           = '0;
    status_set[STAT_OVF] = wrap;
    for (int i = 0; i < NCH; i++) begin
      status_set[stat_ch(i)] = ch_evt[i];
    end
    status_d = (status_q & ~irq_clr_i) | status_set;
  end

  // Shared timebase, trigger and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q     <= '0;
      count_q   <= '0;
      trigger_q <= 1'b0;
      status_q  <= '0;
    end else begin
      psc_q     <= psc_d;
      count_q   <= count_d;
      trigger_q <= trigger_d;
      status_q  <= status_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    general_timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .mode_i      (ch_mode_i[g]),
      .cmp_i       (cmp_i[g*CNT_W +: CNT_W]),
      .count_i     (count_q),
      .count_nxt_i (count_d),
      .adv_i       (adv),
      .capture_i   (capture_i[g]),
      .pwm_o       (pwm_o[g]),
      .cap_val_o   (cap_val_o[g*CNT_W +: CNT_W]),
      .event_o     (ch_evt[g])
    );
  end

  assign count_o   = count_q;
  assign trigger_o = trigger_q;
  assign status_o  = status_q;
  assign irq       = |(status_q & irq_en_i);

endmodule

// File: tb/tb_general_timer_mc.sv
// Directed bench for general_timer_mc with a cycle-stamped expectation scoreboard.
// Stimulus pushes expectations tagged with the cycle they are due; a negedge monitor pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_general_timer_mc;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  localparam int S_CNT  = 0;
  localparam int S_PWM  = 1;
  localparam int S_TRIG = 2;
  localparam int S_STAT = 3;
  localparam int S_IRQ  = 4;
  localparam int S_CAP  = 5;
  localparam int S_CAP3 = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en_i;
  logic                 sw_clr_i;
  logic [PSC_W-1:0]     prescale_i;
  logic [CNT_W-1:0]     period_i;
  logic [NCH-1:0]       ch_mode_i;
  logic [NCH*CNT_W-1:0] cmp_i;
  logic [NCH-1:0]       capture_i;
  logic [NCH:0]         irq_en_i;
  logic [NCH:0]         irq_clr_i;
  logic [CNT_W-1:0]     count_o;
  logic [NCH*CNT_W-1:0] cap_val_o;
  logic [NCH-1:0]       pwm_o;
  logic                 trigger_o;
  logic [NCH:0]         status_o;
  logic                 irq;

  general_timer_mc #(.NCH(NCH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .sw_clr_i   (sw_clr_i),
    .prescale_i (prescale_i),
    .period_i   (period_i),
    .ch_mode_i  (ch_mode_i),
    .cmp_i      (cmp_i),
    .capture_i  (capture_i),
    .irq_en_i   (irq_en_i),
    .irq_clr_i  (irq_clr_i),
    .count_o    (count_o),
    .cap_val_o  (cap_val_o),
    .pwm_o      (pwm_o),
    .trigger_o  (trigger_o),
    .status_o   (status_o),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sel;
    logic [63:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(input int at, input int sel, input logic [63:0] v, input string nm);
    exp_t e;
    int   idx;
    e.at = at; e.sel = sel; e.v = v; e.nm = nm;
    idx = exp_q.size();
    while (idx > 0 && exp_q[idx-1].at > at) idx--;
    exp_q.insert(idx, e);
  endfunction

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      S_CNT:   return 64'(count_o);
      S_PWM:   return 64'(pwm_o);
      S_TRIG:  return 64'(trigger_o);
      S_STAT:  return 64'(status_o);
      S_IRQ:   return 64'(irq);
      S_CAP:   return 64'(cap_val_o);
      S_CAP3:  return 64'(cap_val_o[3*CNT_W +: CNT_W]);
      default: return '1;
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle against the sampled outputs.
  exp_t        mon_e;
  logic [63:0] mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = probe(mon_e.sel);
      checks++;
      if (mon_e.at != cyc || mon_act !== mon_e.v) begin
        errors++;
        $display("FAIL %s cyc %0d (due %0d): got %0h expected %0h",
                 mon_e.nm, cyc, mon_e.at, mon_act, mon_e.v);
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int B, P, Q, R, c;
    rst = 1'b1; en_i = 1'b0; sw_clr_i = 1'b0; prescale_i = '0; period_i = '0;
    ch_mode_i = '0; cmp_i = '0; capture_i = '0; irq_en_i = '0; irq_clr_i = '0;

    // Reset values while reset is held.
    push(1, S_CNT, 0, "rst_count"); push(1, S_PWM, 0, "rst_pwm");
    push(1, S_TRIG, 0, "rst_trig"); push(1, S_STAT, 0, "rst_status");
    push(1, S_IRQ, 0, "rst_irq");   push(1, S_CAP, 0, "rst_capval");

    // Free-running count 0..9 with overflow trigger/status/irq.
    goto(2);
    rst = 1'b0; en_i = 1'b1; prescale_i = 8'd0; period_i = 16'd9;
    ch_mode_i = 4'hF; irq_en_i = 5'b00001;
    B = cyc;
    for (int k = 1; k <= 20; k++) begin
      push(B + k, S_CNT, 64'(k % 10), "p9_count");
      push(B + k, S_TRIG, 64'(k % 10 == 0), "p9_trigger");
    end
    push(B + 9, S_IRQ, 0, "p9_irq_before_wrap");
    push(B + 10, S_STAT, 5'b00001, "p9_status_ovf");
    push(B + 10, S_IRQ, 1, "p9_irq_on_wrap");

    goto(B + 20);
    irq_en_i = 5'b00000;
    push(B + 21, S_IRQ, 0, "irq_masked");
    push(B + 21, S_STAT, 5'b00001, "status_sticky");
    goto(B + 21);
    irq_clr_i = 5'b00001;
    goto(B + 22);
    irq_clr_i = '0; irq_en_i = 5'b00001;
    push(B + 22, S_STAT, 0, "clr_alone_status");
    push(B + 22, S_IRQ, 0, "clr_alone_irq");

    // Software clear on the cycle that would otherwise wrap.
    goto(B + 29);
    sw_clr_i = 1'b1;
    push(B + 30, S_CNT, 0, "swclr_count");
    push(B + 30, S_TRIG, 0, "swclr_no_trigger");
    push(B + 30, S_STAT, 0, "swclr_no_status");
    push(B + 31, S_CNT, 1, "swclr_restart");
    goto(B + 30);
    sw_clr_i = 1'b0;

    // Clear collides with a fresh wrap: set wins; then a lone clear drops it and irq.
    goto(B + 49);
    irq_clr_i = 5'b00001;
    push(B + 50, S_STAT, 5'b00001, "collide_status");
    push(B + 50, S_IRQ, 1, "collide_irq");
    push(B + 50, S_TRIG, 1, "collide_trigger");
    goto(B + 50);
    irq_clr_i = '0;
    goto(B + 51);
    irq_clr_i = 5'b00001;
    push(B + 52, S_STAT, 0, "clr_after_collide");
    push(B + 52, S_IRQ, 0, "irq_after_clear");
    goto(B + 52);
    irq_clr_i = '0;

    // Prescale 3, period 4, ch0 compare at 2.
    P = B + 60;
    goto(P);
    sw_clr_i = 1'b1; prescale_i = 8'd3; period_i = 16'd4;
    cmp_i = {16'd0, 16'd0, 16'd0, 16'd2}; ch_mode_i = 4'b1110;
    irq_clr_i = 5'h1F; irq_en_i = 5'b00001;
    for (int k = 1; k <= 24; k++) begin
      c = ((k - 1) / 4) % 5;
      push(P + k, S_CNT, 64'(c), "psc_count");
      push(P + k, S_PWM, 64'(c < 2), "psc_pwm0");
      push(P + k, S_TRIG, 64'(k == 21), "psc_trigger");
    end
    push(P + 8, S_STAT, 0, "cmp_before_match");
    push(P + 9, S_STAT, 5'b00010, "cmp_match_status");
    push(P + 9, S_IRQ, 0, "cmp_irq_masked");
    push(P + 21, S_STAT, 5'b00011, "psc_wrap_status");
    push(P + 21, S_IRQ, 1, "psc_wrap_irq");
    goto(P + 1);
    sw_clr_i = 1'b0; irq_clr_i = '0;

    // cmp=0 stays low, cmp>period stays high and never matches; ch3 capture.
    Q = P + 30;
    goto(Q);
    sw_clr_i = 1'b1; prescale_i = 8'd0; period_i = 16'd9;
    cmp_i = {16'd0, 16'd20, 16'd0, 16'd2}; ch_mode_i = 4'b1000;
    irq_clr_i = 5'h1F; irq_en_i = 5'b10000;
    for (int k = 1; k <= 12; k++) begin
      c = (k - 1) % 10;
      push(Q + k, S_CNT, 64'(c), "edge_count");
      push(Q + k, S_PWM, {60'd0, 1'b0, 1'b1, 1'b0, 1'(c < 2)}, "edge_pwm");
    end
    push(Q + 10, S_STAT, 5'b00010, "edge_status_prewrap");
    push(Q + 11, S_STAT, 5'b00111, "edge_status_wrap");
    goto(Q + 1);
    sw_clr_i = 1'b0; irq_clr_i = '0;

    goto(Q + 16);
    capture_i = 4'b1000;
    push(Q + 18, S_CAP3, 0, "cap_not_yet");
    push(Q + 18, S_IRQ, 0, "cap_irq_not_yet");
    push(Q + 19, S_CAP3, 7, "cap_first");
    push(Q + 19, S_STAT, 5'b10111, "cap_status");
    push(Q + 19, S_IRQ, 1, "cap_irq");
    goto(Q + 22);
    capture_i = '0;
    goto(Q + 28);
    capture_i = 4'b1000;
    push(Q + 30, S_CAP3, 7, "cap_hold");
    push(Q + 31, S_CAP3, 9, "cap_overwrite");
    push(Q + 31, S_CAP, 64'h0009_0000_0000_0000, "cap_all_channels");

    // Asynchronous reset mid-count with PWM high.
    R = Q + 40;
    goto(R);
    sw_clr_i = 1'b1; cmp_i = {16'd0, 16'd20, 16'd0, 16'd8};
    push(R + 6, S_CNT, 5, "prerst_count");
    push(R + 6, S_PWM, 4'b0101, "prerst_pwm");
    goto(R + 1);
    sw_clr_i = 1'b0;
    goto(R + 7);
    rst = 1'b1;
    push(R + 7, S_CNT, 0, "arst_count"); push(R + 7, S_PWM, 0, "arst_pwm");
    push(R + 7, S_TRIG, 0, "arst_trig"); push(R + 7, S_STAT, 0, "arst_status");
    push(R + 7, S_IRQ, 0, "arst_irq");   push(R + 7, S_CAP, 0, "arst_capval");
    goto(R + 8);
    rst = 1'b0;
    push(R + 8, S_CNT, 0, "postrst_count0");
    push(R + 9, S_CNT, 1, "postrst_count1");

    goto(R + 12);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
